// File: rtl/dct_acc_descale.sv
// Sums TERMS signed products per DCT coefficient, then rounds, descales and saturates the sum.
// The result sits in a one-entry output register with a valid/ready handshake.
module dct_acc_descale #(
  parameter int PROD_WIDTH = 29,
  parameter int ACC_WIDTH  = 32,
  parameter int TERMS      = 8,
  parameter int SHIFT      = 13,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [PROD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err
);

  localparam int CNT_W = (TERMS > 2) ? $clog2(TERMS) : 1;
  localparam int EXT_W = ACC_WIDTH - PROD_WIDTH;
  localparam int SAT_W = ACC_WIDTH + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERMS - 1);
  localparam logic signed [SAT_W-1:0] ROUND_BIAS = SAT_W'(1) << (SHIFT - 1);
  localparam logic signed [SAT_W-1:0] SAT_MAX =
    {{(SAT_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [SAT_W-1:0] SAT_MIN =
    {{(SAT_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  // Reset asserts asynchronously; its release is delayed two clocks so every flop leaves reset on the same edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync_q <= '0;
    else           rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;
  logic                        err_q, err_d;

  logic                        accept;
  logic                        is_final;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [SAT_W-1:0]     round_sum;
  logic signed [SAT_W-1:0]     shifted;
  logic [OUT_WIDTH-1:0]        sat_val;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can leave one unassigned and infer a latch.
    in_ready    = !out_valid_q || out_ready;
    accept      = in_valid && in_ready;
    is_final    = (cnt_q == CNT_LAST);
    prod_ext    = {{EXT_W{in_data[PROD_WIDTH-1]}}, in_data};
    sum         = acc_q + prod_ext;
    // One guard bit keeps the rounding bias from wrapping a near-full-scale positive sum.
    round_sum   = {sum[ACC_WIDTH-1], sum} + ROUND_BIAS;
    shifted     = round_sum >>> SHIFT;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[OUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[OUT_WIDTH-1:0];
    else                        sat_val = shifted[OUT_WIDTH-1:0];

    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = err_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      cnt_d = is_final ? '0 : cnt_q + CNT_W'(1);
      acc_d = (cnt_q == '0) ? prod_ext : sum;
      if (is_final) begin
        out_valid_d = 1'b1;
        out_data_d  = sat_val;
      end
      // The counter stays authoritative; a misplaced in_last only raises the sticky flag.
      if (in_last != is_final) err_d = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together from pre-edge values.
  always_ff @(posedge ap_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule
